// File: rtl/i2s_receiver.sv
// i2s_receiver: Philips I2S deserialiser producing MSB-aligned left/right pairs.
// Tolerates any slot length; short slots are zero-padded and flagged.
module i2s_receiver #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  serial_clk,
    input  logic                  reset,
    input  logic                  word_select,
    input  logic                  sound_bit_in,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid,
    output logic                  slot_error,
    output logic                  locked
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } state_t;

    state_t                  state_q, state_d;
    logic                    ws_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [DATA_WIDTH-1:0]   left_q, left_d;
    logic [DATA_WIDTH-1:0]   right_q, right_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    locked_q, locked_d;

    logic                    fall, rise, short_slot;
    logic [CW-1:0]           cap_cnt;
    logic [DATA_WIDTH-1:0]   cap_shift, closed;

    // Bit capture (saturating), slot-close alignment and FSM next state.
    always_comb begin
        fall      = ws_q & ~word_select;
        rise      = ~ws_q & word_select;
        cap_shift = shift_q;
        cap_cnt   = cnt_q;
        if (cnt_q < FULL) begin
            cap_shift = {shift_q[DATA_WIDTH-2:0], sound_bit_in};
            cap_cnt   = cnt_q + 1'b1;
        end
        closed     = cap_shift << (FULL - cap_cnt);
        short_slot = cap_cnt < FULL;

        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        hold_d   = hold_q;
        left_d   = left_q;
        right_d  = right_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        locked_d = locked_q;

        unique case (state_q)
            SYNC: begin
                if (fall) begin
                    state_d  = LEFT;
                    cnt_d    = '0;
                    shift_d  = '0;
                    locked_d = 1'b1;
                end
            end
            LEFT: begin
                if (rise) begin
                    hold_d  = closed;
                    err_d   = short_slot;
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = RIGHT;
                end else if (fall) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    shift_d = '0;
                end else begin
                    cnt_d   = cap_cnt;
                    shift_d = cap_shift;
                end
            end
            RIGHT: begin
                if (fall) begin
                    right_d = closed;
                    left_d  = hold_q;
                    valid_d = 1'b1;
                    err_d   = short_slot;
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = LEFT;
                end else begin
                    cnt_d   = cap_cnt;
                    shift_d = cap_shift;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // State and output registers; reset drops any partial slot.
    always_ff @(posedge serial_clk) begin
        if (reset) begin
            state_q  <= SYNC;
            ws_q     <= 1'b1;
            cnt_q    <= '0;
            shift_q  <= '0;
            hold_q   <= '0;
            left_q   <= '0;
            right_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ws_q     <= word_select;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            hold_q   <= hold_d;
            left_q   <= left_d;
            right_q  <= right_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign left_sample  = left_q;
    assign right_sample = right_q;
    assign sample_valid = valid_q;
    assign slot_error   = err_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed I2S frames driven on the falling bit-clock edge,
// outputs captured on the falling edge and checked against hand-computed values.
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws;
    logic        sd;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic        slot_error;
    logic        locked;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int err_cnt = 0;
    int lock_cyc = -1;
    int first_fall_cyc = -1;
    logic pend = 1'b0;

    logic [15:0] lq[$];
    logic [15:0] rq[$];
    logic        eq[$];
    int          vq[$];

    logic [15:0] exp_l[8];
    logic [15:0] exp_r[8];
    logic        exp_e[8];

    i2s_receiver #(.DATA_WIDTH(16)) dut (
        .serial_clk  (clk),
        .reset       (reset),
        .word_select (ws),
        .sound_bit_in(sd),
        .left_sample (left_sample),
        .right_sample(right_sample),
        .sample_valid(sample_valid),
        .slot_error  (slot_error),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse seen between rising edges.
    always @(negedge clk) begin
        if (sample_valid) begin
            lq.push_back(left_sample);
            rq.push_back(right_sample);
            eq.push_back(slot_error);
            vq.push_back(cyc);
        end
        if (slot_error) err_cnt++;
        if (locked && lock_cyc < 0) lock_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One slot of n bit-clocks; data lags WS by one clock (Philips format).
    task automatic drive_slot(input logic ws_v, input logic [15:0] word,
                              input int nbits, input int n, input logic pad);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            ws = ws_v;
            sd = pend;
            if (!ws_v && first_fall_cyc < 0) first_fall_cyc = cyc;
            pend = (k < nbits) ? word[nbits-1-k] : pad;
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r,
                         input int nl, input int nr, input logic padl);
        drive_slot(1'b0, l, 16, nl, padl);
        drive_slot(1'b1, r, 16, nr, 1'b0);
    endtask

    initial begin
        exp_l = '{16'd150, 16'd300, 16'd450, 16'h8001,
                  16'hA5A5, 16'h0F0F, 16'h1111, 16'h1357};
        exp_r = '{16'h0000, 16'h0000, 16'h0000, 16'h7FFE,
                  16'h1234, 16'hFF00, 16'h2222, 16'hFEDC};
        exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        ws    = 1'b1;
        sd    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_left", left_sample, 0);
        chk("rst_right", right_sample, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_err", slot_error, 0);
        chk("rst_locked", locked, 0);
        reset = 1'b0;

        drive_slot(1'b1, 16'h0, 0, 40, 1'b0);
        chk("ws_high_locked", locked, 0);
        chk("ws_high_novalid", lq.size(), 0);

        frame(16'd150, 16'd0, 17, 17, 1'b0);
        frame(16'd300, 16'd0, 17, 17, 1'b0);
        frame(16'd450, 16'd0, 17, 17, 1'b0);
        frame(16'h8001, 16'h7FFE, 16, 16, 1'b0);
        frame(16'hA5A5, 16'h1234, 32, 32, 1'b1);
        drive_slot(1'b0, 16'h0F0F, 16, 16, 1'b0);
        drive_slot(1'b1, 16'h00FF, 8, 8, 1'b0);
        frame(16'h1111, 16'h2222, 16, 16, 1'b0);

        drive_slot(1'b0, 16'h5555, 16, 8, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_left", left_sample, 0);
        chk("midrst_right", right_sample, 0);
        chk("midrst_valid", sample_valid, 0);
        chk("midrst_locked", locked, 0);
        chk("pairs_before_rst", lq.size(), 7);
        reset = 1'b0;
        ws    = 1'b1;
        drive_slot(1'b1, 16'h0, 0, 16, 1'b0);
        frame(16'h1357, 16'hFEDC, 16, 16, 1'b0);
        drive_slot(1'b0, 16'h0, 16, 4, 1'b0);
        @(negedge clk);

        chk("pair_count", lq.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < lq.size()) begin
                chk($sformatf("left[%0d]", i), lq[i], exp_l[i]);
                chk($sformatf("right[%0d]", i), rq[i], exp_r[i]);
                chk($sformatf("err[%0d]", i), eq[i], exp_e[i]);
            end else begin
                checks++;
                errors++;
                $error("FAIL pair[%0d]: got none expected %0h/%0h",
                       i, exp_l[i], exp_r[i]);
            end
        end
        if (vq.size() >= 3) begin
            chk("period_0", vq[1] - vq[0], 34);
            chk("period_1", vq[2] - vq[1], 34);
            chk("first_pair_lat", vq[0] - lock_cyc, 34);
        end else begin
            checks++;
            errors++;
            $error("FAIL periods: got %0d pulses expected 3+", vq.size());
        end
        chk("lock_latency", lock_cyc - first_fall_cyc, 1);
        chk("slot_err_count", err_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
